// File: rtl/audio_pcm_scheduler.sv
// Audio PCM scheduler: buffers 16-bit stereo sample pairs in a small FIFO and
// releases one pair every period+1 clocks. Each released pair is attenuated,
// rounded and saturated to PCM_BITS before it reaches the DAC/PWM stage.
module audio_pcm_scheduler #(
  parameter int unsigned PCM_BITS   = 12,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PREFILL    = 4,
  parameter int unsigned DIV_BITS   = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [DIV_BITS-1:0]         period,
  input  logic [3:0]                  atten,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [15:0]          in_left,
  input  logic signed [15:0]          in_right,
  output logic signed [PCM_BITS-1:0]  pcm_left,
  output logic signed [PCM_BITS-1:0]  pcm_right,
  output logic                        sample_strobe,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        underrun,
  input  logic                        underrun_clr
);

  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW   = AddrW + 1;
  // Half an output LSB, added before truncating the low input bits.
  localparam int unsigned RndInt = 1 << (15 - PCM_BITS);
  localparam int unsigned Shift  = 16 - PCM_BITS;
  localparam int unsigned MaxInt = (1 << (PCM_BITS - 1)) - 1;

  typedef enum logic [1:0] {
    StIdle,
    StPrefill,
    StRun
  } state_e;

  state_e state_q, state_d;

  logic [DIV_BITS-1:0] div_q, div_d;
  logic [AddrW-1:0]    wr_q, wr_d;
  logic [AddrW-1:0]    rd_q, rd_d;
  logic [LvlW-1:0]     level_q, level_d;
  logic                pend_q, pend_d;
  logic [PCM_BITS-1:0] conv_l_q, conv_l_d;
  logic [PCM_BITS-1:0] conv_r_q, conv_r_d;
  logic [PCM_BITS-1:0] pcm_l_q, pcm_l_d;
  logic [PCM_BITS-1:0] pcm_r_q, pcm_r_d;
  logic                strobe_q, strobe_d;
  logic                underrun_q, underrun_d;
  // Holds in_ready low until the first clock after reset release.
  logic                ready_q;

  logic                wr_en;
  logic                pop;
  logic                tick;

  logic [15:0] mem_l [FIFO_DEPTH];
  logic [15:0] mem_r [FIFO_DEPTH];

  // Attenuate, round to nearest and clip the positive overflow of one channel.
  function automatic logic [PCM_BITS-1:0] to_pcm(input logic signed [15:0] s,
                                                 input logic [3:0]          sh);
    logic signed [15:0] a;
    logic signed [16:0] sum;
    logic signed [16:0] r;
    a   = s >>> sh;
    sum = $signed({a[15], a}) + $signed(17'(RndInt));
    r   = sum >>> Shift;
    if (r > $signed(17'(MaxInt))) begin
      return PCM_BITS'(MaxInt);
    end
    return r[PCM_BITS-1:0];
  endfunction

  // Ready depends on registered state only, never on in_valid.
  assign in_ready      = ready_q && (level_q < LvlW'(FIFO_DEPTH));
  assign level         = level_q;
  assign pcm_left      = pcm_l_q;
  assign pcm_right     = pcm_r_q;
  assign sample_strobe = strobe_q;
  assign underrun      = underrun_q;

  // Next-state logic: FSM, divider, FIFO pointers, output pipeline, underrun flag.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    level_d    = level_q;
    pend_d     = 1'b0;
    conv_l_d   = conv_l_q;
    conv_r_d   = conv_r_q;
    pcm_l_d    = pcm_l_q;
    pcm_r_d    = pcm_r_q;
    strobe_d   = 1'b0;
    underrun_d = underrun_q & ~underrun_clr;
    tick       = 1'b0;
    pop        = 1'b0;
    wr_en      = in_valid && in_ready && enable && (state_q != StIdle);

    // A pair popped last cycle reaches the outputs now.
    if (pend_q) begin
      pcm_l_d  = conv_l_q;
      pcm_r_d  = conv_r_q;
      strobe_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        wr_d    = '0;
        rd_d    = '0;
        level_d = '0;
        div_d   = period;
        pcm_l_d = '0;
        pcm_r_d = '0;
        if (enable) begin
          state_d = StPrefill;
        end
      end
      StPrefill: begin
        div_d = period;
        if (level_q >= LvlW'(PREFILL)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        tick  = (div_q == '0);
        div_d = tick ? period : div_q - DIV_BITS'(1);
        if (tick) begin
          if (level_q != '0) begin
            pop = 1'b1;
          end else begin
            underrun_d = 1'b1;
            state_d    = StPrefill;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_en) begin
      wr_d = wr_q + AddrW'(1);
    end
    if (pop) begin
      rd_d     = rd_q + AddrW'(1);
      pend_d   = 1'b1;
      // atten is applied here, at pop time, not when the pair was pushed.
      conv_l_d = to_pcm(mem_l[rd_q], atten);
      conv_r_d = to_pcm(mem_r[rd_q], atten);
    end
    if (state_q != StIdle) begin
      level_d = level_q + LvlW'(wr_en) - LvlW'(pop);
    end

    // Disabling flushes everything, including a pop still in the pipeline.
    if (!enable) begin
      state_d  = StIdle;
      wr_d     = '0;
      rd_d     = '0;
      level_d  = '0;
      div_d    = period;
      pend_d   = 1'b0;
      pcm_l_d  = '0;
      pcm_r_d  = '0;
      strobe_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      pend_q     <= 1'b0;
      conv_l_q   <= '0;
      conv_r_q   <= '0;
      pcm_l_q    <= '0;
      pcm_r_q    <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      level_q    <= level_d;
      pend_q     <= pend_d;
      conv_l_q   <= conv_l_d;
      conv_r_q   <= conv_r_d;
      pcm_l_q    <= pcm_l_d;
      pcm_r_q    <= pcm_r_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
      ready_q    <= 1'b1;
    end
  end

  // FIFO storage; no reset needed since occupancy is tracked by level_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_l[wr_q] <= in_left;
      mem_r[wr_q] <= in_right;
    end
  end

endmodule

// File: tb/tb_audio_pcm_scheduler.sv
// Directed bench for audio_pcm_scheduler with default parameters
// (PCM_BITS=12, FIFO_DEPTH=8, PREFILL=4, DIV_BITS=16) and period=3.
module tb_audio_pcm_scheduler;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [15:0] period;
  logic [3:0]  atten;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_left;
  logic [15:0] in_right;
  logic [11:0] pcm_left;
  logic [11:0] pcm_right;
  logic        sample_strobe;
  logic [3:0]  level;
  logic        underrun;
  logic        underrun_clr;

  int checks = 0;
  int errors = 0;

  audio_pcm_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .period       (period),
    .atten        (atten),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_left      (in_left),
    .in_right     (in_right),
    .pcm_left     (pcm_left),
    .pcm_right    (pcm_right),
    .sample_strobe(sample_strobe),
    .level        (level),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] l, input logic [15:0] r);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    step();
  endtask

  // Steps until sample_strobe is seen; n = number of clocks taken (40 = timeout).
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_strobe && n < 40);
  endtask

  initial begin
    int n;
    int cnt;
    reset_n      = 1'b0;
    enable       = 1'b0;
    period       = 16'd3;
    atten        = 4'd0;
    in_valid     = 1'b0;
    in_left      = '0;
    in_right     = '0;
    underrun_clr = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_level", level, 0);
    chk("rst_pcm_l", pcm_left, 0);
    chk("rst_strobe", sample_strobe, 0);
    chk("rst_underrun", underrun, 0);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready_low", in_ready, 0);
    step();
    chk("rel_in_ready_high", in_ready, 1);

    // Basic playback: 4 pairs of (0x1234, 0xEDCC)
    enable = 1'b1;
    step();
    repeat (4) drive(16'h1234, 16'hEDCC);
    in_valid = 1'b0;
    chk("prefill_level", level, 4);
    wait_strobe(n);
    chk("first_strobe_lat", n, 6);
    chk("pcm_l_123", pcm_left, 12'h123);
    chk("pcm_r_edd", pcm_right, 12'hEDD);
    chk("level_after_pop1", level, 3);
    wait_strobe(n);
    chk("strobe_spacing1", n, 4);
    step();
    chk("strobe_one_cycle", sample_strobe, 0);
    wait_strobe(n);
    chk("strobe_spacing2", n, 3);
    chk("level_after_pop3", level, 1);
    wait_strobe(n);
    chk("strobe_spacing3", n, 4);
    chk("level_empty", level, 0);

    // Underrun on the next empty tick; set wins over simultaneous clear
    repeat (2) step();
    chk("no_underrun_yet", underrun, 0);
    underrun_clr = 1'b1;
    step();
    chk("underrun_set_wins", underrun, 1);
    chk("underrun_pcm_hold", pcm_left, 12'h123);
    chk("underrun_no_strobe", sample_strobe, 0);
    step();
    chk("underrun_cleared", underrun, 0);
    underrun_clr = 1'b0;

    // Refill from PREFILL: conversion corner cases and atten at pop time
    drive(16'h7FFF, 16'h8000);
    drive(16'h0008, 16'hFFF7);
    drive(16'h4000, 16'hC000);
    drive(16'h4000, 16'h0010);
    in_valid = 1'b0;
    chk("refill_level", level, 4);
    wait_strobe(n);
    chk("resume_lat", n, 6);
    chk("sat_pos", pcm_left, 12'h7FF);
    chk("neg_full", pcm_right, 12'h800);
    wait_strobe(n);
    chk("round_up", pcm_left, 12'h001);
    chk("round_neg", pcm_right, 12'hFFF);
    atten = 4'd4;
    wait_strobe(n);
    chk("atten4_pos", pcm_left, 12'h040);
    chk("atten4_neg", pcm_right, 12'hFC0);
    atten = 4'd0;
    wait_strobe(n);
    chk("atten0_again_l", pcm_left, 12'h400);
    chk("atten0_again_r", pcm_right, 12'h001);

    // Disable zeroes the outputs next cycle
    enable = 1'b0;
    step();
    chk("disable_pcm", pcm_left, 0);
    chk("disable_level", level, 0);

    // Full FIFO with in_valid held: pair j encodes to pcm +j / -j
    enable = 1'b1;
    step();
    for (int j = 1; j <= 8; j++) begin
      drive(16'(16 * j), 16'(-16 * j));
    end
    in_left  = 16'(16 * 9);
    in_right = 16'(-16 * 9);
    chk("full_level", level, 8);
    chk("full_not_ready", in_ready, 0);
    step();
    chk("full_pop_level", level, 7);
    chk("ready_after_pop", in_ready, 1);
    step();
    chk("full_strobe", sample_strobe, 1);
    chk("no_overwrite_l", pcm_left, 12'h001);
    chk("no_overwrite_r", pcm_right, 12'hFFF);
    chk("refull_level", level, 8);
    in_valid = 1'b0;
    repeat (3) step();
    chk("tick_pop_level", level, 7);

    // Disable between tick and strobe: in-flight pop discarded
    enable = 1'b0;
    step();
    chk("dis_mid_level", level, 0);
    chk("dis_mid_pcm_l", pcm_left, 0);
    chk("dis_mid_strobe", sample_strobe, 0);
    step();
    chk("dis_mid_strobe2", sample_strobe, 0);

    // Reset between tick and strobe
    enable = 1'b1;
    step();
    repeat (4) drive(16'h1234, 16'hEDCC);
    in_valid = 1'b0;
    wait_strobe(n);
    chk("rerun_lat", n, 6);
    chk("rerun_pcm", pcm_left, 12'h123);
    repeat (3) step();
    chk("pre_reset_level", level, 2);
    reset_n = 1'b0;
    #1;
    chk("async_rst_pcm_l", pcm_left, 0);
    chk("async_rst_pcm_r", pcm_right, 0);
    chk("async_rst_level", level, 0);
    chk("async_rst_ready", in_ready, 0);
    chk("async_rst_strobe", sample_strobe, 0);
    step();
    chk("in_rst_strobe", sample_strobe, 0);
    reset_n = 1'b1;
    #1;
    chk("post_rel_ready_low", in_ready, 0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (sample_strobe) cnt++;
    end
    chk("no_strobe_after_rst", cnt, 0);
    chk("post_rel_ready_high", in_ready, 1);
    chk("post_rel_pcm", pcm_left, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
